// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arm_pkg
// Brief   : Shared types and default constants for the data memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package arm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam int unsigned ARM_BASE_ADDR   = 32'd1024;
  localparam int          ARM_DEPTH_WORDS = 64;
  localparam int          ARM_WAIT_CYCLES = 3;
  localparam int          ARM_CNT_W       = 4;

  // Index width that stays legal for a single-word memory.
  function automatic int arm_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : arm_pkg
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_array
// Brief   : DEPTH_WORDS x 32 storage, synchronous write, combinational read.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_array
  import arm_pkg::*;
#(
  parameter int DEPTH_WORDS = ARM_DEPTH_WORDS,
  parameter int IDX_W       = arm_idx_width(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  // Contents survive reset, so the array has no reset term.
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : data_mem_array
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Multi-cycle MEM-stage responder with wait states, range checking,
//           pipeline freeze and a one-cycle completion strobe.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_responder
  import arm_pkg::*;
#(
  parameter int          WAIT_CYCLES = ARM_WAIT_CYCLES,
  parameter int          DEPTH_WORDS = ARM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = ARM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        freeze
);

  localparam int                   IDX_W      = arm_idx_width(DEPTH_WORDS);
  localparam int                   CNT_W      = ARM_CNT_W;
  localparam logic [32:0]          C_SPAN     = 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0]     C_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     C_CNT_ONE  = CNT_W'(1);

  mem_state_e        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [31:0]       rdata_q,   rdata_d;
  logic              err_q,     err_d;
  logic              wr_pend_q, wr_pend_d;
  logic [IDX_W-1:0]  widx_q,    widx_d;
  logic [31:0]       wdata_q,   wdata_d;

  logic              w_req;
  logic              w_both;
  logic [31:0]       w_offset;
  logic              w_valid;
  logic              w_bad;
  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_mem_rdata;
  logic              w_mem_we;

  assign w_req    = mem_r_en | mem_w_en;
  assign w_both   = mem_r_en & mem_w_en;
  assign w_offset = addr - BASE_ADDR;
  // Offset is only meaningful once addr >= BASE_ADDR, which the first term guards.
  assign w_valid  = (addr >= BASE_ADDR) && ({1'b0, w_offset} < C_SPAN) && (addr[1:0] == 2'b00);
  assign w_bad    = ~w_valid | w_both;
  assign w_idx    = w_offset[IDX_W+1:2];
  assign w_mem_we = (state_q == ST_DONE) & wr_pend_q;

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (w_mem_we),
    .waddr_i (widx_q),
    .wdata_i (wdata_q),
    .raddr_i (w_idx),
    .rdata_o (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      wr_pend_q <= wr_pend_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    wr_pend_d = 1'b0;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          state_d = ST_WAIT;
          cnt_d   = C_CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - C_CNT_ONE;
        end else begin
          // Resolve the access here; the write itself lands on the DONE->IDLE edge.
          state_d   = ST_DONE;
          err_d     = w_bad;
          wr_pend_d = mem_w_en & ~w_bad;
          widx_d    = w_idx;
          wdata_d   = wdata;
          if (w_bad) begin
            rdata_d = '0;
          end else if (mem_r_en) begin
            rdata_d = w_mem_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready  = (state_q == ST_DONE);
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign freeze = w_req & ~ready;

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Directed self-checking bench with a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int          W     = 3;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        freeze;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  data_mem_responder #(
    .WAIT_CYCLES (W),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .freeze   (freeze)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * DEPTH) && (x % 4 == 0);
  endfunction

  // Reference model: word index -> contents, plus the age of the current access.
  logic [31:0] mdl_mem [int];
  int          age = -1;
  logic [31:0] exp_rdata = '0;
  bit          rdata_known = 1'b1;

  always @(negedge clk) begin : compare
    bit   req;
    bit   exp_ready;
    bit   exp_err;
    int   idx;
    req = mem_r_en | mem_w_en;
    if (rst) begin
      age = -1;
      exp_rdata = '0;
      rdata_known = 1'b1;
      check("rst_ready", 32'(ready), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      check("rst_rdata", rdata, 32'h0);
      check("rst_freeze", 32'(freeze), 32'(req));
    end else begin
      if (age < 0 && req) age = 0;
      else if (age >= 1 && age <= W && !req) age = -1;
      exp_ready = (age == W + 1);
      exp_err = 1'b0;
      idx = int'((addr - BASE) >> 2);
      if (exp_ready) begin
        exp_err = !addr_ok(addr) || (mem_r_en && mem_w_en);
        if (exp_err) begin
          exp_rdata = '0;
          rdata_known = 1'b1;
        end else if (mem_r_en) begin
          rdata_known = mdl_mem.exists(idx);
          if (rdata_known) exp_rdata = mdl_mem[idx];
        end
      end
      check("ready", 32'(ready), 32'(exp_ready));
      check("err", 32'(err), 32'(exp_err));
      check("freeze", 32'(freeze), 32'(req && !exp_ready));
      if (rdata_known) check("rdata", rdata, exp_rdata);
      if (exp_ready) begin
        if (mem_w_en && !exp_err) mdl_mem[idx] = wdata;
        age = -1;
      end else if (age >= 0) begin
        age++;
      end
    end
  end

  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, output int lat, output int rcyc, output int frz,
                        output logic [31:0] rd, output logic e);
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
    lat = 0; rcyc = -1; frz = 0; rd = '0; e = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        rd = rdata; e = err; rcyc = cyc;
        break;
      end
      if (freeze) frz++;
      lat++;
    end
    if (rcyc < 0) check("access_timeout", 32'(0), 32'(1));
    if (!keep) begin
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
    end
  endtask

  initial begin : stim
    int lat, rc1, rc2, frz, nready;
    logic [31:0] rd;
    logic e;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'(0));
    check("reset_err", 32'(err), 32'(0));
    check("reset_rdata", rdata, 32'h0);
    check("reset_freeze", 32'(freeze), 32'(0));
    rst = 1'b0;

    access(0, 1, 32'd1024, 32'hDEADBEEF, 0, lat, rc1, frz, rd, e);
    check("wr1024_latency", 32'(lat), 32'd4);
    check("wr1024_err", 32'(e), 32'd0);
    check("wr1024_freeze_cycles", 32'(frz), 32'd4);

    access(1, 0, 32'd1024, 32'h0, 0, lat, rc1, frz, rd, e);
    check("rd1024_latency", 32'(lat), 32'd4);
    check("rd1024_data", rd, 32'hDEADBEEF);
    check("rd1024_err", 32'(e), 32'd0);

    access(1, 0, 32'd1026, 32'h0, 0, lat, rc1, frz, rd, e);
    check("misaligned_err", 32'(e), 32'd1);
    check("misaligned_rdata", rd, 32'h0);
    access(1, 0, 32'd1280, 32'h0, 0, lat, rc1, frz, rd, e);
    check("oor_high_err", 32'(e), 32'd1);
    check("oor_high_rdata", rd, 32'h0);
    access(1, 0, 32'd1020, 32'h0, 0, lat, rc1, frz, rd, e);
    check("oor_low_err", 32'(e), 32'd1);
    access(1, 0, 32'd1024, 32'h0, 0, lat, rc1, frz, rd, e);
    check("rd1024_after_err", rd, 32'hDEADBEEF);

    access(0, 1, 32'd1276, 32'hCAFEF00D, 0, lat, rc1, frz, rd, e);
    check("last_word_wr_err", 32'(e), 32'd0);
    access(1, 0, 32'd1276, 32'h0, 0, lat, rc1, frz, rd, e);
    check("last_word_rd", rd, 32'hCAFEF00D);

    access(1, 1, 32'd1024, 32'h11111111, 0, lat, rc1, frz, rd, e);
    check("both_en_err", 32'(e), 32'd1);
    check("both_en_rdata", rd, 32'h0);
    access(1, 0, 32'd1024, 32'h0, 0, lat, rc1, frz, rd, e);
    check("rd1024_after_both", rd, 32'hDEADBEEF);

    access(0, 1, 32'd1028, 32'hA1A1A1A1, 1, lat, rc1, frz, rd, e);
    check("b2b_first_latency", 32'(lat), 32'd4);
    access(0, 1, 32'd1032, 32'hB2B2B2B2, 0, lat, rc2, frz, rd, e);
    check("b2b_second_latency", 32'(lat), 32'd4);
    check("b2b_ready_spacing", 32'(rc2 - rc1), 32'd5);
    access(1, 0, 32'd1028, 32'h0, 0, lat, rc1, frz, rd, e);
    check("rd1028", rd, 32'hA1A1A1A1);
    access(1, 0, 32'd1032, 32'h0, 0, lat, rc1, frz, rd, e);
    check("rd1032", rd, 32'hB2B2B2B2);

    access(0, 1, 32'd1036, 32'h5A5A0036, 0, lat, rc1, frz, rd, e);
    access(0, 1, 32'd1040, 32'h0BAD1040, 0, lat, rc1, frz, rd, e);

    // Flush: request dropped in cycle 2 of the access.
    @(posedge clk); #1;
    mem_w_en = 1'b1; addr = 32'd1036; wdata = 32'h12345678;
    nready = 0;
    @(negedge clk); if (ready) nready++;
    @(negedge clk); if (ready) nready++;
    @(posedge clk); #1;
    mem_w_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    check("flush_no_ready", 32'(nready), 32'd0);
    access(1, 0, 32'd1036, 32'h0, 0, lat, rc1, frz, rd, e);
    check("rd1036_after_flush", rd, 32'h5A5A0036);

    // Reset in the middle of a write's wait states.
    @(posedge clk); #1;
    mem_w_en = 1'b1; addr = 32'd1040; wdata = 32'hFFFF0000;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1; mem_w_en = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'(0));
    check("midrst_err", 32'(err), 32'(0));
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    access(1, 0, 32'd1040, 32'h0, 0, lat, rc1, frz, rd, e);
    check("rd1040_after_rst", rd, 32'h0BAD1040);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_mem_responder
`default_nettype wire
